// File: rtl/comparador_pkg.sv
// -----------------------------------------------------------------------------
// comparador_pkg
//   Shared types for the constant-compare sequence detector.
//   cmp_mode_t : compare operator selected by cfg_mode (unsigned in_data vs const)
//   state_t    : detector FSM state
// -----------------------------------------------------------------------------
package comparador_pkg;

    typedef enum logic [1:0] {
        MODE_EQ = 2'b00,
        MODE_NE = 2'b01,
        MODE_GT = 2'b10,
        MODE_LT = 2'b11
    } cmp_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARMED  = 2'b01,
        ST_COUNT  = 2'b10,
        ST_DETECT = 2'b11
    } state_t;

endpackage

// File: rtl/comparador_core.sv
// -----------------------------------------------------------------------------
// comparador_core
//   Purely combinational compare of one sample against the stored constant.
//   Ports:
//     data  in  WIDTH  sample operand
//     cst   in  WIDTH  comparison constant
//     mode  in  2      compare operator (cmp_mode_t)
//     mask  in  WIDTH  bit-select mask, 1 = bit compared (CMP_MASK_EN only)
//     hit   out 1      compare result
//   Build option: CMP_MASK_EN adds the mask port; both operands are masked
//   before every operator, so an all-zero mask makes EQ always hit.
// -----------------------------------------------------------------------------
module comparador_core
    import comparador_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] cst,
    input  cmp_mode_t        mode,
`ifdef CMP_MASK_EN
    input  logic [WIDTH-1:0] mask,
`endif
    output logic             hit
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

`ifdef CMP_MASK_EN
    assign a = data & mask;
    assign b = cst  & mask;
`else
    assign a = data;
    assign b = cst;
`endif

    always_comb begin
        hit = 1'b0;
        case (mode)
            MODE_EQ: hit = (a == b);
            MODE_NE: hit = (a != b);
            MODE_GT: hit = (a >  b);
            MODE_LT: hit = (a <  b);
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/comparador_const_seq.sv
// -----------------------------------------------------------------------------
// comparador_const_seq
//   Compares each valid sample against a configured constant and, once armed,
//   detects HITS consecutive qualifying samples.
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     cfg_load           capture cfg_const/cfg_mode (IDLE only)
//     cfg_const [W]      comparison constant
//     cfg_mode  [2]      00 EQ, 01 NE, 10 GT, 11 LT
//     cfg_mask  [W]      compare mask, 1 = bit compared (CMP_MASK_EN only)
//     arm                start a detection run (IDLE only)
//     clr                abort run, back to IDLE (highest priority)
//     in_valid, in_data  sample stream
//     match, match_valid registered compare result, 1-cycle update pulse
//     run_cnt [CNT_W]    consecutive-hit count
//     detect             high while in DETECT
//     busy               high whenever not IDLE
//   Build option: CMP_MASK_EN enables the masked compare and its register.
// -----------------------------------------------------------------------------
module comparador_const_seq
    import comparador_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int HITS  = 3,
    localparam int CNT_W = $clog2(HITS+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] cfg_const,
    input  logic [1:0]       cfg_mode,
`ifdef CMP_MASK_EN
    input  logic [WIDTH-1:0] cfg_mask,
`endif
    input  logic             arm,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             match,
    output logic             match_valid,
    output logic [CNT_W-1:0] run_cnt,
    output logic             detect,
    output logic             busy
);

    localparam logic [CNT_W-1:0] HITS_C = CNT_W'(HITS);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    logic [WIDTH-1:0] cst_q;
    cmp_mode_t        mode_q;
    logic             hit;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt_n, cnt_inc;

    // Configuration: only writable while idle, and clr wins over a load.
    wire cfg_we = cfg_load && !clr && (state == ST_IDLE);

`ifdef CMP_MASK_EN
    logic [WIDTH-1:0] mask_q;

    always_ff @(posedge clk) begin
        if (rst)         mask_q <= '1;
        else if (cfg_we) mask_q <= cfg_mask;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cst_q  <= '0;
            mode_q <= MODE_EQ;
        end else if (cfg_we) begin
            cst_q  <= cfg_const;
            mode_q <= cmp_mode_t'(cfg_mode);
        end
    end

    comparador_core #(.WIDTH(WIDTH)) u_core (
        .data (in_data),
        .cst  (cst_q),
        .mode (mode_q),
`ifdef CMP_MASK_EN
        .mask (mask_q),
`endif
        .hit  (hit)
    );

    // Match path runs in every state and is independent of clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            match       <= 1'b0;
            match_valid <= 1'b0;
        end else begin
            match_valid <= in_valid;
            if (in_valid) match <= hit;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = run_cnt;
        cnt_inc = run_cnt + ONE_C;
        if (clr) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        state_n = ST_ARMED;
                        cnt_n   = '0;
                    end
                end
                ST_ARMED: begin
                    if (in_valid && hit) begin
                        cnt_n   = ONE_C;
                        state_n = (HITS == 1) ? ST_DETECT : ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (in_valid) begin
                        if (hit) begin
                            cnt_n   = cnt_inc;
                            state_n = (cnt_inc == HITS_C) ? ST_DETECT : ST_COUNT;
                        end else begin
                            cnt_n   = '0;
                            state_n = ST_ARMED;
                        end
                    end
                end
                ST_DETECT: cnt_n = HITS_C;
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            run_cnt <= '0;
        end else begin
            state   <= state_n;
            run_cnt <= cnt_n;
        end
    end

    // Both decode a register, so detect lines up with the match_valid of the
    // HITS-th qualifying sample.
    assign detect = (state == ST_DETECT);
    assign busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_comparador_const_seq.sv
`timescale 1ns/1ps
module tb_comparador_const_seq;

    localparam int WIDTH = 4;
    localparam int HITS  = 3;
    localparam int CNT_W = $clog2(HITS+1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_load = 1'b0;
    logic [WIDTH-1:0] cfg_const = '0;
    logic [1:0]       cfg_mode = 2'b00;
`ifdef CMP_MASK_EN
    logic [WIDTH-1:0] cfg_mask = '1;
`endif
    logic             arm = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             match, match_valid, detect, busy;
    logic [CNT_W-1:0] run_cnt;

    always #5 clk = ~clk;

    comparador_const_seq #(.WIDTH(WIDTH), .HITS(HITS)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_const   (cfg_const),
        .cfg_mode    (cfg_mode),
`ifdef CMP_MASK_EN
        .cfg_mask    (cfg_mask),
`endif
        .arm         (arm),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .match       (match),
        .match_valid (match_valid),
        .run_cnt     (run_cnt),
        .detect      (detect),
        .busy        (busy)
    );

    typedef struct {
        logic m;
        int   cnt;
        logic det;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: each sample's expectations are checked on its match_valid.
    always @(negedge clk) begin
        if (match_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("mv_unexpected", 0, 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("match", match, e.m);
                chk("run_cnt", run_cnt, e.cnt);
                chk("detect", detect, e.det);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [WIDTH-1:0] c, input logic [1:0] m, input logic [WIDTH-1:0] mk);
        cfg_load  = 1'b1;
        cfg_const = c;
        cfg_mode  = m;
`ifdef CMP_MASK_EN
        cfg_mask  = mk;
`else
        if (mk != '1) $display("note: mask %b ignored in this build", mk);
`endif
        step();
        cfg_load = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic m, input int cnt, input logic det);
        exp_t e;
        e.m = m; e.cnt = cnt; e.det = det;
        sb.push_back(e);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_detect"}, detect, 0);
        chk({tag, "_cnt"}, run_cnt, 0);
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rst_match", match, 0);
        chk("rst_mv", match_valid, 0);
        chk_idle("rst");
        rst = 1'b0;

        // EQ basic compare in IDLE: not counted
        load(4'b0101, 2'b00, 4'b1111);
        send(4'b0101, 1, 0, 0);
        send(4'b0100, 0, 0, 0);
        send(4'b0101, 1, 0, 0);
        step();
        chk("hold_match", match, 1);
        chk("hold_mv", match_valid, 0);
        chk_idle("idle_nocount");

        // Three hits -> DETECT
        arm = 1'b1; step(); arm = 1'b0;
        chk("armed_busy", busy, 1);
        chk("armed_cnt", run_cnt, 0);
        send(4'b0101, 1, 1, 0);
        send(4'b0101, 1, 2, 0);
        send(4'b0101, 1, 3, 1);
        step();
        chk("det_hold", detect, 1);
        send(4'b0000, 0, 3, 1);            // detect persists, count saturated
        load(4'b0000, 2'b10, 4'b0000);     // ignored while busy
        clr = 1'b1; step(); clr = 1'b0;
        chk_idle("clr_det");

        // Broken run: 1,2,0,1 and no detect; then clr with a matching sample
        arm = 1'b1; step(); arm = 1'b0;
        send(4'b0101, 1, 1, 0);
        send(4'b0101, 1, 2, 0);
        send(4'b0011, 0, 0, 0);
        send(4'b0101, 1, 1, 0);
        send(4'b0101, 1, 2, 0);
        clr = 1'b1;
        send(4'b0101, 1, 0, 0);
        clr = 1'b0;
        chk_idle("clr_sample");

        // cfg_load in ARMED ignored; clr beats cfg_load in IDLE
        arm = 1'b1; step(); arm = 1'b0;
        load(4'b1111, 2'b01, 4'b1111);
        send(4'b0101, 1, 1, 0);
        clr = 1'b1;
        load(4'b1111, 2'b01, 4'b1111);
        clr = 1'b0;
        send(4'b0101, 1, 0, 0);

        // GT / LT / NE
        load(4'b0111, 2'b10, 4'b1111);
        send(4'b1000, 1, 0, 0);
        send(4'b0111, 0, 0, 0);
        load(4'b0111, 2'b11, 4'b1111);
        send(4'b0000, 1, 0, 0);
        send(4'b1111, 0, 0, 0);
        load(4'b0111, 2'b01, 4'b1111);
        send(4'b0111, 0, 0, 0);
        send(4'b0001, 1, 0, 0);

        // arm together with cfg_load in IDLE: both apply
        arm = 1'b1;
        load(4'b1010, 2'b00, 4'b1111);
        arm = 1'b0;
        chk("armload_busy", busy, 1);
        send(4'b1010, 1, 1, 0);
        send(4'b1011, 0, 0, 0);
        clr = 1'b1; step(); clr = 1'b0;

`ifdef CMP_MASK_EN
        load(4'b0100, 2'b00, 4'b1100);
        send(4'b0111, 1, 0, 0);
        send(4'b1100, 0, 0, 0);
        load(4'b1001, 2'b00, 4'b0000);
        send(4'b0110, 1, 0, 0);
        load(4'b0100, 2'b00, 4'b1100);
`else
        load(4'b0100, 2'b00, 4'b1111);
`endif
        // rst mid-DETECT
        arm = 1'b1; step(); arm = 1'b0;
        send(4'b0100, 1, 1, 0);
        send(4'b0100, 1, 2, 0);
        send(4'b0100, 1, 3, 1);
        chk("pre_rst_det", detect, 1);
        rst = 1'b1; arm = 1'b1; in_valid = 1'b1; in_data = 4'b0100;
        step();
        rst = 1'b0; arm = 1'b0; in_valid = 1'b0;
        chk("rst2_match", match, 0);
        chk("rst2_mv", match_valid, 0);
        chk_idle("rst2");
        // After reset: const 0, EQ, full mask
        send(4'b0000, 1, 0, 0);
        send(4'b1111, 0, 0, 0);

        step(); step();
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/comparador_const_seq.md
COMPARADOR_CONST_SEQ -- requirements
Module: comparador_const_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand and constant width in bits (>=1).
REQ-002 SHALL have parameter: HITS, 3, consecutive qualifying samples required for detection (>=1).
REQ-003 SHALL derive localparam CNT_W = $clog2(HITS+1).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port: rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port: cfg_load  in  1  capture cfg_const/cfg_mode.
REQ-008 SHALL have port: cfg_const  in  WIDTH  comparison constant.
REQ-009 SHALL have port: cfg_mode  in  2  00 EQ, 01 NE, 10 GT, 11 LT (unsigned, in_data vs constant).
REQ-010 SHALL have port: arm  in  1  start detection run.
REQ-011 SHALL have port: clr  in  1  abort/clear detection, return to IDLE.
REQ-012 SHALL have port: in_valid  in  1  in_data qualifier.
REQ-013 SHALL have port: in_data  in  WIDTH  sample to compare.
REQ-014 SHALL have port: match  out  1  registered compare result of last valid sample.
REQ-015 SHALL have port: match_valid  out  1  one-cycle pulse, match updated.
REQ-016 SHALL have port: run_cnt  out  CNT_W  current consecutive-hit count.
REQ-017 SHALL have port: detect  out  1  high while in DETECT.
REQ-018 SHALL have port: busy  out  1  high when state != IDLE.

Function
REQ-019 SHALL compute hit combinationally from in_data and the config registers per cfg_mode; match/match_valid registered, latency 1 cycle after in_valid; match holds between valid samples.
REQ-020 SHALL accept cfg_load only in IDLE; ignored otherwise; new config applies to samples from the next cycle.
REQ-021 SHALL implement FSM IDLE, ARMED, COUNT, DETECT.
REQ-022 IDLE: arm -> ARMED, run_cnt=0; samples still produce match but are not counted.
REQ-023 ARMED: in_valid&hit -> COUNT, run_cnt=1 (HITS==1 -> DETECT directly); in_valid&!hit stays.
REQ-024 COUNT: in_valid&hit increments run_cnt; reaching HITS -> DETECT; in_valid&!hit -> ARMED, run_cnt=0; no valid -> hold.
REQ-025 DETECT: detect=1, run_cnt saturates at HITS; remains until clr.
REQ-026 clr SHALL take priority over arm, cfg_load and sample in every state: next state IDLE, run_cnt=0, detect=0; match path unaffected.
REQ-027 arm outside IDLE SHALL be ignored; arm and cfg_load together in IDLE: both take effect.
REQ-028 detect SHALL assert the cycle after the HITS-th qualifying sample, coincident with its match_valid.

Reset
REQ-029 On rst: state IDLE, constant 0, mode EQ, match=0, match_valid=0, run_cnt=0, detect=0, busy=0; rst overrides all inputs.

Configuration
REQ-030 With CMP_MASK_EN defined: add port cfg_mask in WIDTH (1=bit compared), captured on cfg_load, reset all-ones; all modes compare (in_data & mask) vs (const & mask); mask all-zeros makes EQ always hit.
REQ-031 Without CMP_MASK_EN: port absent, full-width compare, no mask register.

Structure
REQ-032 SHALL place cmp_mode_t (2-bit enum), state_t enum and mode encodings in package comparador_pkg.
REQ-033 SHALL instantiate one combinational sub-module comparador_core (operands, constant, mode, optional mask -> hit).

Verification
REQ-034 WIDTH=4, EQ, const 4'b0101; in_valid with 0101 -> match=1, match_valid pulse next cycle; 0100 -> match=0.
REQ-035 HITS=3, armed, valid samples 0101,0101,0101 -> run_cnt 1,2,3, detect=1 cycle after third.
REQ-036 Samples 0101,0101,0011,0101 -> run_cnt 1,2,0,1; no detect.
REQ-037 GT const 4'b0111: 1000 -> match=1, 0111 -> 0; LT: 0000 -> 1, 1111 -> 0.
REQ-038 In COUNT with run_cnt=2, clr and matching sample same cycle -> IDLE, run_cnt=0, match=1; cfg_load while busy ignored.
REQ-039 CMP_MASK_EN, mask 4'b1100, const 0100, EQ: 0111 -> match=1, 1100 -> 0; rst mid-DETECT -> all outputs 0 next cycle.
